// File: rtl/krnl_acc_axi_ctrl_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : krnl_acc_ctrl_pkg
// Description : Shared definitions for the kernel control-register AXI4-Lite
//               initiator: FSM state encoding, response codes, control
//               register map and CTRL register bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package krnl_acc_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_REQ  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_REQ  = 3'd3,
    ST_RD_DATA = 3'd4,
    ST_RSP     = 3'd5
  } state_t;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  // Kernel control slave register map (byte addresses)
  localparam logic [11:0] ADDR_CTRL            = 12'h000;
  localparam logic [11:0] ADDR_CFG_CI          = 12'h010;
  localparam logic [11:0] ADDR_CFG_CO          = 12'h014;
  localparam logic [11:0] ADDR_IFM_SIZE        = 12'h018;
  localparam logic [11:0] ADDR_WGT_SIZE        = 12'h01C;
  localparam logic [11:0] ADDR_OFM_SIZE        = 12'h020;
  localparam logic [11:0] ADDR_IFM_ADDR_BASE_0 = 12'h040;
  localparam logic [11:0] ADDR_IFM_ADDR_BASE_1 = 12'h044;
  localparam logic [11:0] ADDR_WGT_ADDR_BASE_0 = 12'h048;
  localparam logic [11:0] ADDR_WGT_ADDR_BASE_1 = 12'h04C;
  localparam logic [11:0] ADDR_OFM_ADDR_BASE_0 = 12'h050;
  localparam logic [11:0] ADDR_OFM_ADDR_BASE_1 = 12'h054;

  // CTRL register bit indices
  localparam int CTRL_START    = 0;
  localparam int CTRL_DONE     = 1;
  localparam int CTRL_IDLE     = 2;
  localparam int CTRL_READY    = 3;
  localparam int CTRL_CONTINUE = 4;

endpackage
`default_nettype wire

// File: rtl/krnl_acc_axi_ctrl_master_if.sv
`default_nettype none
// ============================================================================
// Module      : krnl_acc_axi_ctrl_master_if
// Description : Bundles the command/response stream and the AXI4-Lite
//               initiator channels (AW, W, B, AR, R).
//               modport master : view of the initiator block
//               modport slave  : view of the command source + AXI slave
// Revision    : 1.0 - initial release
// ============================================================================
interface krnl_acc_axi_ctrl_master_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
);
  // command / response stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W/8-1:0] cmd_wstrb;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_resp;
  // AXI4-Lite
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [DATA_W-1:0] WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_resp,
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface
`default_nettype wire

// File: rtl/krnl_acc_axi_timeout_cnt.sv
`default_nettype none
// ============================================================================
// Module      : krnl_acc_axi_timeout_cnt
// Description : Saturating response-timeout counter. Held at zero while
//               clear is high, otherwise counts up once per cycle and stops
//               at TIMEOUT_CYCLES, where expired is asserted.
// Ports       : clk, rst_n (async active-low), clear, expired
// Revision    : 1.0 - initial release
// ============================================================================
module krnl_acc_axi_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire  clk,
  input  wire  rst_n,
  input  wire  clear,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;

  assign expired = (r_cnt == CNT_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (clear) begin
      r_cnt <= '0;
    end else if (!expired) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/krnl_acc_axi_ctrl_master.sv
`default_nettype none
// ============================================================================
// Module      : krnl_acc_axi_ctrl_master
// Description : AXI4-Lite initiator converting a command/response stream into
//               single-beat control-register reads and writes, one
//               transaction outstanding at a time.
// Ports       : ACLK, ARESETn (async active-low), bus (master modport:
//               cmd/rsp stream + AW/W/B/AR/R channels), busy (state != IDLE)
// Options     : AXI_MST_TIMEOUT_EN - abort with rsp_resp = 2'b11 when the
//               slave does not finish within TIMEOUT_CYCLES cycles
// Revision    : 1.0 - initial release
// ============================================================================
module krnl_acc_axi_ctrl_master
  import krnl_acc_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 12,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  wire  ACLK,
  input  wire  ARESETn,
  krnl_acc_axi_ctrl_master_if.master bus,
  output logic busy
);

  if (DATA_W != 32) begin : g_data_w_check
    $error("krnl_acc_axi_ctrl_master: DATA_W must be 32");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
    $error("krnl_acc_axi_ctrl_master: TIMEOUT_CYCLES must be >= 1");
  end

  state_t              r_state;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W/8-1:0] r_wstrb;
  logic                r_awvalid, r_wvalid, r_arvalid, r_bready, r_rready;
  logic                r_aw_done, r_w_done;
  logic                r_rsp_valid, r_rsp_write;
  logic [DATA_W-1:0]   r_rsp_rdata;
  logic [1:0]          r_rsp_resp;

  logic w_aw_fire, w_w_fire, w_active, w_timeout;

  assign w_aw_fire = r_awvalid & bus.AWREADY;
  assign w_w_fire  = r_wvalid  & bus.WREADY;
  // States in which the initiator is waiting on the slave
  assign w_active  = (r_state == ST_WR_REQ) || (r_state == ST_WR_RESP) ||
                     (r_state == ST_RD_REQ) || (r_state == ST_RD_DATA);

`ifdef AXI_MST_TIMEOUT_EN
  // Counter sits at zero in IDLE/RSP, so it restarts on every request entry.
  krnl_acc_axi_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk     (ACLK),
    .rst_n   (ARESETn),
    .clear   (!w_active),
    .expired (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_bready    <= 1'b0;
      r_rready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= RESP_OKAY;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            r_addr      <= bus.cmd_addr;
            r_wdata     <= bus.cmd_wdata;
            r_wstrb     <= bus.cmd_wstrb;
            r_rsp_write <= bus.cmd_write;
            if (bus.cmd_write) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= ST_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_REQ;
            end
          end
        end
        ST_WR_REQ: begin
          // AW and W complete independently, in either order or together
          if (w_aw_fire) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_fire) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
            r_bready <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (bus.BVALID) begin
            r_bready    <= 1'b0;
            r_rsp_write <= 1'b1;
            r_rsp_resp  <= bus.BRESP;
            r_rsp_rdata <= '0;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end
        end
        ST_RD_REQ: begin
          if (bus.ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (bus.RVALID) begin
            r_rready    <= 1'b0;
            r_rsp_write <= 1'b0;
            r_rsp_resp  <= bus.RRESP;
            r_rsp_rdata <= bus.RDATA;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RSP;
          end
        end
        ST_RSP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      // Timeout overrides whatever the state logic decided this cycle
      if (w_timeout && w_active) begin
        r_awvalid   <= 1'b0;
        r_wvalid    <= 1'b0;
        r_arvalid   <= 1'b0;
        r_bready    <= 1'b0;
        r_rready    <= 1'b0;
        r_rsp_resp  <= RESP_TIMEOUT;
        r_rsp_rdata <= '0;
        r_rsp_valid <= 1'b1;
        r_state     <= ST_RSP;
      end
    end
  end

  assign bus.cmd_ready = (r_state == ST_IDLE);
  assign busy          = (r_state != ST_IDLE);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_write = r_rsp_write;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_resp  = r_rsp_resp;
  assign bus.AWADDR    = r_addr;
  assign bus.AWVALID   = r_awvalid;
  assign bus.WDATA     = r_wdata;
  assign bus.WSTRB     = r_wstrb;
  assign bus.WVALID    = r_wvalid;
  assign bus.BREADY    = r_bready;
  assign bus.ARADDR    = r_addr;
  assign bus.ARVALID   = r_arvalid;
  assign bus.RREADY    = r_rready;

endmodule
`default_nettype wire
